// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} rx_state_t;

  localparam int unsigned DEF_CLKS_PER_BIT = 10;
  localparam int unsigned DEF_DATA_BITS    = 8;

  // Cycles from start edge to the middle of the start bit.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  // Bit-period counter width; must hold the full bit period.
  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return $clog2(clks_per_bit + 1);
  endfunction

  // Bit-index counter width.
  function automatic int unsigned idx_width(input int unsigned data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Line and byte-delivery signals between the receiver and its consumer.
interface uart_rx_ctrl_if import uart_pkg::*; #(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
);

  logic                 serial_in;
  logic                 data_read;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 rx_busy;

  modport master (
    output serial_in, data_read,
    input  data_out, data_valid, framing_error, overrun_error, rx_busy
  );

  modport slave (
    input  serial_in, data_read,
    output data_out, data_valid, framing_error, overrun_error, rx_busy
  );

endinterface

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer and falling-edge detector for the serial line.
// The detector is only armed once a genuine high has been sampled after
// reset, so a line that is already low at reset release is not a start.
module rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic sync_out,
  output logic fall_edge
);

  logic       meta;
  logic       sync;
  logic       prev;
  logic       armed;
  logic [1:0] fill;

  // Synchronize, remember the previous sample, and track real samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      prev  <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      meta  <= serial_in;
      sync  <= meta;
      prev  <= sync;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & sync);
    end
  end

  assign sync_out  = sync;
  assign fall_edge = armed & prev & ~sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1-style serial receiver: detects start, samples mid-bit, frames and
// delivers bytes with sticky valid, framing and overrun flags.
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.slave bus
);

  localparam int unsigned HALF = half_bit(CLKS_PER_BIT);
  localparam int unsigned CW   = cnt_width(CLKS_PER_BIT);
  localparam int unsigned IW   = idx_width(DATA_BITS);

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n, cnt_inc, period;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] dout, dout_n;
  logic                 stop_bit, stop_bit_n;
  logic                 valid, valid_n;
  logic                 fe, fe_n;
  logic                 ovr, ovr_n;
  logic                 busy, busy_n;
  logic                 roll;
  logic                 sync;
  logic                 fall;

  rx_sync_edge u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .serial_in (bus.serial_in),
    .sync_out  (sync),
    .fall_edge (fall)
  );

  // Bit-period rollover: half a bit in START, a full bit elsewhere.
  assign period  = (state == START) ? CW'(HALF) : CW'(CLKS_PER_BIT);
  assign cnt_inc = cnt + CW'(1);
  assign roll    = (cnt_inc == period);

  // Next-state, counters, shift register and output flag updates.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    shift_n    = shift;
    stop_bit_n = stop_bit;
    dout_n     = dout;
    valid_n    = valid;
    fe_n       = fe;
    ovr_n      = ovr;

    if (bus.data_read && valid) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end

    case (state)
      IDLE: begin
        idx_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        if (roll) state_n = sync ? IDLE : DATA;
      end
      DATA: begin
        if (roll) begin
          shift_n = {sync, shift[DATA_BITS-1:1]};
          idx_n   = idx + IW'(1);
          if (idx == IW'(DATA_BITS - 1)) state_n = STOP;
        end
      end
      STOP: begin
        if (roll) begin
          stop_bit_n = sync;
          state_n    = LOAD;
        end
      end
      LOAD: begin
        state_n = IDLE;
        if (stop_bit) begin
          dout_n  = shift;
          valid_n = 1'b1;
          fe_n    = 1'b0;
          ovr_n   = valid & ~bus.data_read;
        end else begin
          fe_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    cnt_n  = (roll || (state_n != state) || (state == IDLE)) ? '0 : cnt_inc;
    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      stop_bit <= 1'b0;
      dout     <= '0;
      valid    <= 1'b0;
      fe       <= 1'b0;
      ovr      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      stop_bit <= stop_bit_n;
      dout     <= dout_n;
      valid    <= valid_n;
      fe       <= fe_n;
      ovr      <= ovr_n;
      busy     <= busy_n;
    end
  end

  assign bus.data_out      = dout;
  assign bus.data_valid    = valid;
  assign bus.framing_error = fe;
  assign bus.overrun_error = ovr;
  assign bus.rx_busy       = busy;

endmodule
